// File: rtl/apb_byte_bridge.sv
// apb_byte_bridge: byte-wide pin interface to a single-transfer APB master.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase wait timeout.
`default_nettype none

// +----------------------------------------------------------------------+
// | Module      : apb_byte_bridge                                        |
// | Description : Synchronises async pin strobes, latches address/data,  |
// |               and runs one APB read or write per strobe.             |
// |               Macro APB_TIMEOUT_EN enables a 255-cycle wait timeout. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apb_byte_bridge (
    input  logic       pclk,
    input  logic       prst,
    input  logic [7:0] data_in,
    input  logic       data_sel,
    input  logic       data_wr,
    input  logic       apb_we,
    input  logic       apb_re,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       err,
    output logic [7:0] paddr,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LAST = 8'd254;
`endif

    logic [2:0] wr_sync_q;
    logic [2:0] we_sync_q;
    logic [2:0] re_sync_q;
    logic       wr_rise_q;
    logic       we_rise_q;
    logic       re_rise_q;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] dout_q, dout_d;
    logic       err_q, err_d;
`ifdef APB_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;
`endif

    // Two synchroniser stages, one edge-history stage; the edge pulse itself
    // is registered so a strobe sampled at edge k reaches SETUP at edge k+3.
    always_ff @(posedge pclk) begin
        if (prst) begin
            wr_sync_q <= 3'b000;
            we_sync_q <= 3'b000;
            re_sync_q <= 3'b000;
            wr_rise_q <= 1'b0;
            we_rise_q <= 1'b0;
            re_rise_q <= 1'b0;
        end else begin
            wr_sync_q <= {wr_sync_q[1:0], data_wr};
            we_sync_q <= {we_sync_q[1:0], apb_we};
            re_sync_q <= {re_sync_q[1:0], apb_re};
            wr_rise_q <= wr_sync_q[1] & ~wr_sync_q[2];
            we_rise_q <= we_sync_q[1] & ~we_sync_q[2];
            re_rise_q <= re_sync_q[1] & ~re_sync_q[2];
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q  <= IDLE;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            paddr_q  <= 8'h00;
            pwdata_q <= 8'h00;
            pwrite_q <= 1'b0;
            dout_q   <= 8'h00;
            err_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
`ifdef APB_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        dout_d   = dout_q;
        err_d    = err_q;
`ifdef APB_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif

        if (wr_rise_q) begin
            if (data_sel) begin
                wdata_d = data_in;
            end else begin
                addr_d = data_in;
            end
        end

        case (state_q)
            IDLE: begin
                // Bus-side copies freeze the transfer even if the pins
                // reload addr/wdata while it is in flight.
                if (we_rise_q || re_rise_q) begin
                    state_d  = SETUP;
                    pwrite_d = we_rise_q;
                    paddr_d  = addr_q;
                    pwdata_d = wdata_q;
                    err_d    = 1'b0;
`ifdef APB_TIMEOUT_EN
                    tmo_d    = 8'h00;
`endif
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    state_d = IDLE;
                    err_d   = pslverr;
                    if (!pwrite_q && !pslverr) begin
                        dout_d = prdata;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_q == c_TMO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign psel     = (state_q != IDLE);
    assign penable  = (state_q == ACCESS);
    assign busy     = (state_q != IDLE);
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign pwrite   = pwrite_q;
    assign data_out = dout_q;
    assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_byte_bridge.sv
// tb_apb_byte_bridge: scoreboard bench for apb_byte_bridge with a simple
// wait-state APB slave model.
`default_nettype none

// +----------------------------------------------------------------------+
// | Module      : tb_apb_byte_bridge                                     |
// | Description : Self-checking bench; expected transfers are queued at  |
// |               launch and compared when the bus completes them.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_apb_byte_bridge;

    logic       pclk = 1'b0;
    logic       prst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_sel = 1'b0;
    logic       data_wr = 1'b0;
    logic       apb_we = 1'b0;
    logic       apb_re = 1'b0;
    logic [7:0] data_out;
    logic       busy;
    logic       err;
    logic [7:0] paddr;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] pwdata;
    logic [7:0] prdata = 8'h00;
    logic       pready;
    logic       pslverr = 1'b0;

    apb_byte_bridge u_dut (
        .pclk     (pclk),
        .prst     (prst),
        .data_in  (data_in),
        .data_sel (data_sel),
        .data_wr  (data_wr),
        .apb_we   (apb_we),
        .apb_re   (apb_re),
        .data_out (data_out),
        .busy     (busy),
        .err      (err),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] dout;
        bit         err;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_xfer   = 0;
    bit   pend     = 1'b0;
    int   wait_n   = 0;
    int   acc_cnt  = 0;

    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_dout  = 8'h00;

    // Slave: inserts wait_n wait states in every ACCESS phase.
    assign pready = psel && penable && (acc_cnt >= wait_n);

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: pops an expectation on each completing ACCESS cycle and
    // checks the pin-side results on the following cycle.
    always @(negedge pclk) begin
        if (pend) begin
            check("data_out", {24'h0, data_out}, {24'h0, cur.dout});
            check("err", {31'h0, err}, {31'h0, cur.err});
            check("busy_after", {31'h0, busy}, 32'h0);
            pend = 1'b0;
        end
        if (!prst && psel && penable && pready) begin
            n_xfer++;
            if (sb.size() == 0) begin
                check("unexpected_xfer", 32'h1, 32'h0);
            end else begin
                cur = sb.pop_front();
                check("pwrite", {31'h0, pwrite}, {31'h0, cur.wr});
                check("paddr", {24'h0, paddr}, {24'h0, cur.addr});
                if (cur.wr) check("pwdata", {24'h0, pwdata}, {24'h0, cur.wdata});
                pend = 1'b1;
            end
        end
    end

    task automatic load(input bit sel, input logic [7:0] v);
        data_sel = sel;
        data_in  = v;
        data_wr  = 1'b1;
        repeat (3) @(negedge pclk);
        data_wr = 1'b0;
        repeat (3) @(negedge pclk);
        if (sel) m_wdata = v;
        else     m_addr  = v;
    endtask

    task automatic push(input bit wr, input logic [7:0] rd, input bit slv, input int waits);
        exp_t e;
        prdata  = rd;
        pslverr = slv;
        wait_n  = waits;
        if (!wr && !slv) m_dout = rd;
        e.wr    = wr;
        e.addr  = m_addr;
        e.wdata = m_wdata;
        e.dout  = m_dout;
        e.err   = slv;
        sb.push_back(e);
    endtask

    task automatic launch(input bit we, input bit re);
        apb_we = we;
        apb_re = re;
        repeat (3) @(negedge pclk);
        apb_we = 1'b0;
        apb_re = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge pclk);
            if (sb.size() == 0 && !pend && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(tag, 32'h0, 32'h1);
    endtask

    task automatic wait_pen(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge pclk);
            if (penable) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(tag, 32'h0, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] psel_v, busy_v, pen_v;
        int         cnt;
        int         x0;
        bit         ok;

        repeat (3) @(negedge pclk);
        check("rst_data_out", {24'h0, data_out}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_psel", {31'h0, psel}, 32'h0);
        check("rst_penable", {31'h0, penable}, 32'h0);
        check("rst_pwrite", {31'h0, pwrite}, 32'h0);
        check("rst_paddr", {24'h0, paddr}, 32'h0);
        check("rst_pwdata", {24'h0, pwdata}, 32'h0);
        prst = 1'b0;
        repeat (2) @(negedge pclk);

        // Write 0x03 to 0x1C, with latency profile from the first sampling edge.
        load(1'b0, 8'h1C);
        load(1'b1, 8'h03);
        push(1'b1, 8'h00, 1'b0, 0);
        apb_we = 1'b1;
        @(posedge pclk);
        for (int j = 0; j < 6; j++) begin
            @(negedge pclk);
            psel_v[j] = psel;
            busy_v[j] = busy;
            pen_v[j]  = penable;
            if (j == 2) apb_we = 1'b0;
        end
        check("lat_psel", {26'h0, psel_v}, 32'b011000);
        check("lat_penable", {26'h0, pen_v}, 32'b010000);
        check("lat_busy", {26'h0, busy_v}, 32'b011000);
        wait_idle("idle_wr1");

        // Read 0x2C with three wait states.
        load(1'b0, 8'h2C);
        push(1'b0, 8'h7F, 1'b0, 3);
        launch(1'b0, 1'b1);
        cnt = 0;
        repeat (12) begin
            @(negedge pclk);
            if (penable) cnt++;
        end
        check("rd_penable_cycles", cnt, 4);
        wait_idle("idle_rd1");

        // Same address reused, then a write with fresh data.
        push(1'b0, 8'h5A, 1'b0, 1);
        launch(1'b0, 1'b1);
        wait_idle("idle_rd2");
        load(1'b1, 8'hA5);
        push(1'b1, 8'h00, 1'b0, 2);
        launch(1'b1, 1'b0);
        wait_idle("idle_wr2");

        // Collision: write wins; a read strobe during the transfer is dropped.
        load(1'b1, 8'hC3);
        push(1'b1, 8'h00, 1'b0, 8);
        x0 = n_xfer;
        launch(1'b1, 1'b1);
        repeat (2) @(negedge pclk);
        launch(1'b0, 1'b1);
        wait_idle("idle_coll");
        repeat (10) @(negedge pclk);
        check("coll_xfer_count", n_xfer - x0, 1);

        // Slave error on a read, then err clears as the next transfer starts.
        push(1'b0, 8'hEE, 1'b1, 0);
        launch(1'b0, 1'b1);
        wait_idle("idle_slverr");
        push(1'b1, 8'h00, 1'b0, 3);
        launch(1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (psel) begin
                ok = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        check("err_clr_seen_psel", {31'h0, ok}, 32'h1);
        check("err_clr", {31'h0, err}, 32'h0);
        wait_idle("idle_errclr");

        // Reset during ACCESS aborts with no completion.
        wait_n = 1000;
        prdata = 8'h99;
        x0 = n_xfer;
        launch(1'b0, 1'b1);
        wait_pen("rst_acc_pen");
        prst = 1'b1;
        @(negedge pclk);
        check("rstacc_psel", {31'h0, psel}, 32'h0);
        check("rstacc_penable", {31'h0, penable}, 32'h0);
        check("rstacc_data_out", {24'h0, data_out}, 32'h0);
        check("rstacc_busy", {31'h0, busy}, 32'h0);
        prst = 1'b0;
        m_addr = 8'h00; m_wdata = 8'h00; m_dout = 8'h00;
        repeat (6) @(negedge pclk);
        check("rstacc_no_xfer", n_xfer - x0, 0);

        // Strobe held high across reset release counts as one new edge.
        apb_re = 1'b1;
        prst = 1'b1;
        repeat (2) @(negedge pclk);
        push(1'b0, 8'h33, 1'b0, 0);
        prst = 1'b0;
        repeat (4) @(negedge pclk);
        apb_re = 1'b0;
        wait_idle("idle_heldrst");

        // Slave never ready.
        load(1'b0, 8'h44);
        wait_n = 100000;
        prdata = 8'h11;
        launch(1'b0, 1'b1);
        wait_pen("tmo_pen");
`ifdef APB_TIMEOUT_EN
        cnt = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge pclk);
            if (!penable) break;
            cnt++;
        end
        check("tmo_wait_cycles", cnt, 255);
        check("tmo_psel", {31'h0, psel}, 32'h0);
        check("tmo_err", {31'h0, err}, 32'h1);
        check("tmo_data_out", {24'h0, data_out}, {24'h0, m_dout});
        check("tmo_busy", {31'h0, busy}, 32'h0);
`else
        repeat (1100) @(negedge pclk);
        check("hang_penable", {31'h0, penable}, 32'h1);
        check("hang_psel", {31'h0, psel}, 32'h1);
        check("hang_data_out", {24'h0, data_out}, {24'h0, m_dout});
        prst = 1'b1;
        @(negedge pclk);
        prst = 1'b0;
        check("hang_rst_penable", {31'h0, penable}, 32'h0);
`endif
        repeat (3) @(negedge pclk);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
